// File: rtl/kernel_filter_pkg.sv
// -----------------------------------------------------------------------------
// kernel_filter_pkg
// Shared constants for the 3x3 convolution stage:
//   - beat-type (dtype) encoding used on the dtypei/dtypeo sideband
//   - tap count and centre-tap index of the packed kernel/coefficient buses
// Kernel and coefficient buses pack tap [r][c] at index (r*3+c); tap 4 is centre.
// -----------------------------------------------------------------------------
package kernel_filter_pkg;

   // Beat types. Frame-start and row-start beats carry a pixel (bit 0 set).
   localparam int                    DTYPE_WIDTH       = 4;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'b0001;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'b0011;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'b0101;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'b1000;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'b0001;

   // Kernel geometry
   localparam int KF_TAPS   = 9;
   localparam int KF_CENTRE = 4;

endpackage

// File: rtl/kernel_filter_tap.sv
// -----------------------------------------------------------------------------
// kernel_filter_tap
// One registered multiplier tap: prod_o = unsigned pixel * signed coefficient.
// Ports:
//   clk, resetb   clock, async active-low reset
//   pix_i         unsigned pixel
//   coef_i        signed two's-complement coefficient
//   prod_o        registered signed product (PIXEL_WIDTH+COEF_WIDTH+1 bits)
// -----------------------------------------------------------------------------
module kernel_filter_tap #(
   parameter int PIXEL_WIDTH = 10,
   parameter int COEF_WIDTH  = 8
) (
   input  logic                                          clk,
   input  logic                                          resetb,
   input  logic        [PIXEL_WIDTH-1:0]                 pix_i,
   input  logic signed [COEF_WIDTH-1:0]                  coef_i,
   output logic signed [PIXEL_WIDTH+COEF_WIDTH:0]        prod_o
);

   localparam int PROD_W = PIXEL_WIDTH + COEF_WIDTH + 1;

   logic signed [PROD_W-1:0] prod_d;

   // Pixel is zero-extended so it is never treated as negative.
   always_comb begin
      prod_d = PROD_W'($signed({1'b0, pix_i})) * PROD_W'(coef_i);
   end

   // Product register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         prod_o <= '0;
      end else begin
         prod_o <= prod_d;
      end
   end

endmodule

// File: rtl/kernel_filter.sv
// -----------------------------------------------------------------------------
// kernel_filter
// Programmable 3x3 convolution with saturation; fixed 3-clock latency.
//   S1: nine registered pixel*coef products (kernel_filter_tap)
//   S2: three row sums
//   S3: total, optional round, arithmetic shift, clamp -> registered outputs
// Coefficients/shift are shadowed and reloaded only on a valid FRAME_START beat,
// which itself already uses the new set. Reset loads the identity set.
// Build option: define KERNEL_FILTER_ROUND_EN to add 1<<(shift-1) before the
// shift (round half up); otherwise the shift truncates (floor).
// Ports:
//   clk, resetb               clock, async active-low reset
//   dvi, dtypei, meta_datai   input beat valid / type / header word
//   kernel_datai              packed 3x3 pixel kernel, centre at tap 4
//   enable                    1 = filter, 0 = pass centre pixel
//   coefs, shift              signed coefficients and normalising shift
//   dvo, dtypeo, meta_datao   sideband delayed 3 clocks
//   datao                     filtered pixel, 0 on non-pixel beats
// -----------------------------------------------------------------------------
module kernel_filter
   import kernel_filter_pkg::*;
#(
   parameter int KERNEL_SIZE = 3,
   parameter int PIXEL_WIDTH = 10,
   parameter int DATA_WIDTH  = 16,
   parameter int COEF_WIDTH  = 8,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                               clk,
   input  logic                               resetb,
   input  logic                               dvi,
   input  logic [DTYPE_WIDTH-1:0]             dtypei,
   input  logic [KF_TAPS*PIXEL_WIDTH-1:0]     kernel_datai,
   input  logic [DATA_WIDTH-1:0]              meta_datai,
   input  logic                               enable,
   input  logic [KF_TAPS*COEF_WIDTH-1:0]      coefs,
   input  logic [SHIFT_WIDTH-1:0]             shift,
   output logic                               dvo,
   output logic [DTYPE_WIDTH-1:0]             dtypeo,
   output logic [DATA_WIDTH-1:0]              meta_datao,
   output logic [PIXEL_WIDTH-1:0]             datao
);

   localparam int PROD_W = PIXEL_WIDTH + COEF_WIDTH + 1;
   localparam int ROW_W  = PROD_W + 2;
   localparam int SUM_W  = PROD_W + 4;
   localparam int RND_W  = SUM_W + 1;   // headroom for the rounding bias
   localparam logic [KF_TAPS*COEF_WIDTH-1:0] COEF_IDENTITY =
      {{((KF_TAPS-1-KF_CENTRE)*COEF_WIDTH){1'b0}}, COEF_WIDTH'(1'b1), {(KF_CENTRE*COEF_WIDTH){1'b0}}};
   localparam logic signed [RND_W-1:0] PIX_MAX = RND_W'({PIXEL_WIDTH{1'b1}});

   if (KERNEL_SIZE != 3) begin : g_bad_kernel_size
      $error("kernel_filter: KERNEL_SIZE must be 3");
   end

   // Shadow coefficient set and the set applied to the current input beat
   logic [KF_TAPS*COEF_WIDTH-1:0] coef_shadow_q, coef_use_s;
   logic [SHIFT_WIDTH-1:0]        shift_shadow_q, shift_use_s;
   logic                          load_s;

   // Pipeline sideband; shift travels with its beat so a reload never
   // affects beats already in flight.
   logic                          s1_dv_q, s2_dv_q;
   logic [DTYPE_WIDTH-1:0]        s1_dtype_q, s2_dtype_q;
   logic [DATA_WIDTH-1:0]         s1_meta_q, s2_meta_q;
   logic                          s1_en_q, s2_en_q;
   logic                          s1_pix_q, s2_pix_q;
   logic [PIXEL_WIDTH-1:0]        s1_centre_q, s2_centre_q;
   logic [SHIFT_WIDTH-1:0]        s1_shift_q, s2_shift_q;

   logic signed [PROD_W-1:0]      prod_s [KF_TAPS];
   logic signed [ROW_W-1:0]       row_q  [3];
   logic signed [SUM_W-1:0]       sum_s;
   logic signed [RND_W-1:0]       rnd_s, shifted_s;
   logic [PIXEL_WIDTH-1:0]        filt_s, datao_d;

   assign load_s = dvi && (dtypei == DTYPE_FRAME_START);

   // Select the coefficient set for the beat entering S1
   always_comb begin
      if (load_s) begin
         coef_use_s  = coefs;
         shift_use_s = shift;
      end else begin
         coef_use_s  = coef_shadow_q;
         shift_use_s = shift_shadow_q;
      end
   end

   // Shadow coefficient registers
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         coef_shadow_q  <= COEF_IDENTITY;
         shift_shadow_q <= '0;
      end else if (load_s) begin
         coef_shadow_q  <= coefs;
         shift_shadow_q <= shift;
      end else begin
         coef_shadow_q  <= coef_shadow_q;
         shift_shadow_q <= shift_shadow_q;
      end
   end

   for (genvar t = 0; t < KF_TAPS; t++) begin : g_tap
      kernel_filter_tap #(
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .COEF_WIDTH  (COEF_WIDTH)
      ) u_tap (
         .clk    (clk),
         .resetb (resetb),
         .pix_i  (kernel_datai[t*PIXEL_WIDTH +: PIXEL_WIDTH]),
         .coef_i (coef_use_s[t*COEF_WIDTH +: COEF_WIDTH]),
         .prod_o (prod_s[t])
      );
   end

   // S1 sideband register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         s1_dv_q     <= 1'b0;
         s1_dtype_q  <= '0;
         s1_meta_q   <= '0;
         s1_en_q     <= 1'b0;
         s1_pix_q    <= 1'b0;
         s1_centre_q <= '0;
         s1_shift_q  <= '0;
      end else begin
         s1_dv_q     <= dvi;
         s1_dtype_q  <= dtypei;
         s1_meta_q   <= meta_datai;
         s1_en_q     <= enable;
         s1_pix_q    <= |(dtypei & DTYPE_PIXEL_MASK);
         s1_centre_q <= kernel_datai[KF_CENTRE*PIXEL_WIDTH +: PIXEL_WIDTH];
         s1_shift_q  <= shift_use_s;
      end
   end

   // S2 row sums and sideband register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int r = 0; r < 3; r++) row_q[r] <= '0;
         s2_dv_q     <= 1'b0;
         s2_dtype_q  <= '0;
         s2_meta_q   <= '0;
         s2_en_q     <= 1'b0;
         s2_pix_q    <= 1'b0;
         s2_centre_q <= '0;
         s2_shift_q  <= '0;
      end else begin
         for (int r = 0; r < 3; r++) begin
            row_q[r] <= ROW_W'(prod_s[3*r]) + ROW_W'(prod_s[3*r+1]) + ROW_W'(prod_s[3*r+2]);
         end
         s2_dv_q     <= s1_dv_q;
         s2_dtype_q  <= s1_dtype_q;
         s2_meta_q   <= s1_meta_q;
         s2_en_q     <= s1_en_q;
         s2_pix_q    <= s1_pix_q;
         s2_centre_q <= s1_centre_q;
         s2_shift_q  <= s1_shift_q;
      end
   end

   // S3 total, round, arithmetic shift, clamp and output select
   always_comb begin
      sum_s = SUM_W'(row_q[0]) + SUM_W'(row_q[1]) + SUM_W'(row_q[2]);
`ifdef KERNEL_FILTER_ROUND_EN
      if (s2_shift_q != '0) begin
         rnd_s = RND_W'(sum_s) + (RND_W'(1'b1) << (s2_shift_q - SHIFT_WIDTH'(1'b1)));
      end else begin
         rnd_s = RND_W'(sum_s);
      end
`else
      rnd_s = RND_W'(sum_s);
`endif
      shifted_s = rnd_s >>> s2_shift_q;
      if (shifted_s[RND_W-1]) begin
         filt_s = '0;
      end else if (shifted_s > PIX_MAX) begin
         filt_s = {PIXEL_WIDTH{1'b1}};
      end else begin
         filt_s = shifted_s[PIXEL_WIDTH-1:0];
      end
      if (s2_dv_q && s2_pix_q) begin
         datao_d = s2_en_q ? filt_s : s2_centre_q;
      end else begin
         datao_d = '0;
      end
   end

   // Output register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         dvo        <= 1'b0;
         dtypeo     <= '0;
         meta_datao <= '0;
         datao      <= '0;
      end else begin
         dvo        <= s2_dv_q;
         dtypeo     <= s2_dtype_q;
         meta_datao <= s2_meta_q;
         datao      <= datao_d;
      end
   end

endmodule

// File: tb/tb_kernel_filter.sv
// -----------------------------------------------------------------------------
// tb_kernel_filter
// Directed self-checking bench for kernel_filter (default parameters).
// Expected values are hand-computed; the rounding-dependent ones follow
// KERNEL_FILTER_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_kernel_filter;
   import kernel_filter_pkg::*;

`ifdef KERNEL_FILTER_ROUND_EN
   localparam int EXP_725 = 91;   // (725+4)>>3
   localparam int EXP_740 = 93;   // (740+4)>>3
`else
   localparam int EXP_725 = 90;   // 725>>3
   localparam int EXP_740 = 92;   // 740>>3
`endif

   logic        clk;
   logic        resetb;
   logic        dvi;
   logic [3:0]  dtypei;
   logic [89:0] kernel_datai;
   logic [15:0] meta_datai;
   logic        enable;
   logic [71:0] coefs;
   logic [3:0]  shift;
   logic        dvo;
   logic [3:0]  dtypeo;
   logic [15:0] meta_datao;
   logic [9:0]  datao;

   int checks;
   int errors;

   kernel_filter u_dut (
      .clk          (clk),
      .resetb       (resetb),
      .dvi          (dvi),
      .dtypei       (dtypei),
      .kernel_datai (kernel_datai),
      .meta_datai   (meta_datai),
      .enable       (enable),
      .coefs        (coefs),
      .shift        (shift),
      .dvo          (dvo),
      .dtypeo       (dtypeo),
      .meta_datao   (meta_datao),
      .datao        (datao)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [89:0] kern(input int v, input int c);
      logic [89:0] k;
      for (int t = 0; t < 9; t++) k[t*10 +: 10] = (t == 4) ? 10'(c) : 10'(v);
      return k;
   endfunction

   function automatic logic [71:0] cset(input int v, input int c);
      logic [71:0] k;
      for (int t = 0; t < 9; t++) k[t*8 +: 8] = (t == 4) ? 8'(c) : 8'(v);
      return k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Send one beat, then check the output lines appear exactly 3 clocks later.
   task automatic send(input string tag, input logic [3:0] dt, input logic [89:0] kd,
                       input logic [15:0] md, input int exp_d);
      @(negedge clk);
      dvi = 1'b1; dtypei = dt; kernel_datai = kd; meta_datai = md;
      @(negedge clk);
      dvi = 1'b0; dtypei = 4'h0; meta_datai = 16'h0000;
      @(negedge clk);
      chk({tag, "_early"}, {31'd0, dvo}, 32'd0);
      @(negedge clk);
      chk({tag, "_dvo"},   {31'd0, dvo}, 32'd1);
      chk({tag, "_dtype"}, {28'd0, dtypeo}, {28'd0, dt});
      chk({tag, "_meta"},  {16'd0, meta_datao}, {16'd0, md});
      chk({tag, "_data"},  {22'd0, datao}, 32'(exp_d));
   endtask

   initial begin
      logic [39:0] gap_pat;
      logic [2:0]  hist;
      logic        nd;
      checks = 0; errors = 0;
      resetb = 1'b0; dvi = 1'b0; dtypei = 4'h0; kernel_datai = '0; meta_datai = 16'h0000;
      enable = 1'b1; coefs = cset(1, 1); shift = 4'd3;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_dvo", {31'd0, dvo}, 32'd0);
      chk("rst_data", {22'd0, datao}, 32'd0);
      chk("rst_meta", {16'd0, meta_datao}, 32'd0);
      resetb = 1'b1;

      // Identity set after reset; box set on the port is not loaded without FRAME_START
      send("ident", DTYPE_PIXEL, kern(100, 517), 16'h1234, 517);

      // Box blur loaded by FRAME_START, which already uses it
      send("box80", DTYPE_FRAME_START, kern(80, 80), 16'h0001, 90);
      send("box725", DTYPE_PIXEL, kern(80, 85), 16'h0002, EXP_725);

      // Mid-frame coefficient change is ignored until the next FRAME_START
      coefs = cset(-1, 9); shift = 4'd0;
      send("shadow_hold", DTYPE_PIXEL, kern(80, 100), 16'h0003, EXP_740);
      send("shadow_fs", DTYPE_FRAME_START, kern(80, 100), 16'h0004, 260);
      send("shadow_new", DTYPE_ROW_START, kern(80, 100), 16'h0005, 260);

      // Saturation with sharpen
      send("sat_flat", DTYPE_PIXEL, kern(1023, 1023), 16'h0006, 1023);
      send("sat_low", DTYPE_PIXEL, kern(1023, 0), 16'h0007, 0);
      send("sat_high", DTYPE_PIXEL, kern(0, 1023), 16'h0008, 1023);

      // Bypass passes the centre pixel
      enable = 1'b0;
      send("bypass", DTYPE_PIXEL, kern(1023, 300), 16'h0009, 300);
      enable = 1'b1;

      // Header beat: sideband passes, data forced to zero
      send("header", DTYPE_HEADER, kern(500, 500), 16'h0500, 0);

      // Back-to-back FRAME_STARTs: each reloads, the last one wins
      @(negedge clk);
      dvi = 1'b1; dtypei = DTYPE_FRAME_START; coefs = cset(0, 1); shift = 4'd0;
      kernel_datai = kern(100, 517); meta_datai = 16'h0011;
      @(negedge clk);
      coefs = cset(1, 1); shift = 4'd3; kernel_datai = kern(80, 80); meta_datai = 16'h0022;
      @(negedge clk);
      dtypei = DTYPE_PIXEL; coefs = cset(-1, 9); shift = 4'd0;
      kernel_datai = kern(80, 85); meta_datai = 16'h0033;
      @(negedge clk);
      dvi = 1'b0; dtypei = 4'h0;
      chk("b2b_0_data", {22'd0, datao}, 32'd517);
      chk("b2b_0_meta", {16'd0, meta_datao}, 32'h0011);
      @(negedge clk);
      chk("b2b_1_data", {22'd0, datao}, 32'd90);
      chk("b2b_1_dvo", {31'd0, dvo}, 32'd1);
      @(negedge clk);
      chk("b2b_2_data", {22'd0, datao}, 32'(EXP_725));
      chk("b2b_2_meta", {16'd0, meta_datao}, 32'h0033);

      // Gapped traffic with an asynchronous reset pulse mid-row
      repeat (3) @(negedge clk);
      gap_pat = 40'b1011_0011_1110_0101_1101_0011_0110_1111_0001_1011;
      hist = 3'b000;
      dtypei = DTYPE_PIXEL; kernel_datai = kern(10, 10); meta_datai = 16'h00AA;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("gap_dvo", {31'd0, dvo}, {31'd0, hist[2]});
         if (i == 22) resetb = 1'b1;
         nd = gap_pat[i];
         dvi = nd;
         hist = {hist[1:0], nd & resetb};
         if (i == 20) begin
            #2 resetb = 1'b0;
            #1;
            chk("rst_mid_dvo", {31'd0, dvo}, 32'd0);
            chk("rst_mid_dtype", {28'd0, dtypeo}, 32'd0);
            chk("rst_mid_meta", {16'd0, meta_datao}, 32'd0);
            chk("rst_mid_data", {22'd0, datao}, 32'd0);
            hist = 3'b000;
         end
      end
      @(negedge clk);
      dvi = 1'b0;
      repeat (4) @(negedge clk);

      // Reset restored the identity set (box was loaded before the pulse)
      coefs = cset(1, 1); shift = 4'd3;
      send("ident_post_rst", DTYPE_PIXEL, kern(100, 517), 16'h0BEE, 517);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
